operand_fetch_unit: RTL and testbench

OPERAND_FETCH_UNIT -- requirements
Module: operand_fetch_unit

---
 rtl/operand_fetch_unit_pkg.sv | 27 ++
 rtl/operand_fetch_unit_register_file.sv | 36 +++
 rtl/operand_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_operand_fetch_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_unit_pkg.sv
// Shared definitions for the operand fetch stage and the ALU.
// Holds the ALU opcode encodings, register index width and zero-register index.
// Contains no logic, so it adds no latency and applies no backpressure.
package operand_fetch_unit_pkg;

    localparam int REG_IDX_W = 5;
    localparam int OPCODE_W  = 4;

    // R31 always reads as zero and ignores writes.
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd31;

    typedef enum logic [OPCODE_W-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SHL   = 4'd5,
        ALU_SHR   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_CMPEQ = 4'd8,
        ALU_CMPLT = 4'd9,
        ALU_CMPLE = 4'd10,
        ALU_PASSB = 4'd11
    } alu_op_e;

endpackage

// File: rtl/operand_fetch_unit_register_file.sv
// Two-read, one-write architectural register file; R31 reads zero.
// Reads are combinational (zero cycles); a write lands at the clock edge.
// No backpressure: a write is accepted every cycle that we is high.
module register_file
    import operand_fetch_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] wa,
    input  logic [DATA_W-1:0]    wd,
    input  logic [REG_IDX_W-1:0] ra_a,
    input  logic [REG_IDX_W-1:0] ra_b,
    output logic [DATA_W-1:0]    rd_a,
    output logic [DATA_W-1:0]    rd_b
);

    // Storage is not reset; only R31 has a defined value, and it is never stored.
    logic [DATA_W-1:0] mem_q [REG_CNT];

    // Write port: writes aimed at the zero register are dropped.
    always_ff @(posedge clk) begin
        if (we && (wa != REG_ZERO)) begin
            mem_q[wa] <= wd;
        end
    end

    // Read ports: the zero register is forced to 0 rather than read from storage.
    always_comb begin
        rd_a = (ra_a == REG_ZERO) ? '0 : mem_q[ra_a];
        rd_b = (ra_b == REG_ZERO) ? '0 : mem_q[ra_b];
    end

endmodule

// File: rtl/operand_fetch_unit.sv
// Operand fetch: register read with EX/MEM/WB bypass, load-use interlock, ALU input register.
// Latency one cycle from an accepted instruction to X/Y/OpCode/RcOut/AluEnable.
// Stall (combinational) asks upstream to hold; a stalled cycle issues a bubble.
module operand_fetch_unit
    import operand_fetch_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 InValid,
    input  logic [4:0]           Ra,
    input  logic [4:0]           Rb,
    input  logic [4:0]           Rc,
    input  logic                 UseLit,
    input  logic [15:0]          Literal,
    input  logic [3:0]           OpCodeIn,
    input  logic                 Flush,
    input  logic                 ExValid,
    input  logic                 ExIsLoad,
    input  logic [4:0]           ExRc,
    input  logic [DATA_W-1:0]    ExZ,
    input  logic                 MemValid,
    input  logic [4:0]           MemRc,
    input  logic [DATA_W-1:0]    MemData,
    input  logic                 WbEnable,
    input  logic [4:0]           WbRc,
    input  logic [DATA_W-1:0]    WbData,
    output logic [DATA_W-1:0]    X,
    output logic [DATA_W-1:0]    Y,
    output logic [3:0]           OpCode,
    output logic                 AluEnable,
    output logic [4:0]           RcOut,
    output logic                 Stall
);

    logic [DATA_W-1:0] rf_a_dat, rf_b_dat;
    logic [DATA_W-1:0] opa_dat, opb_dat;
    logic              rf_we;
    logic              load_use;
    logic              accept;

    logic [DATA_W-1:0] x_d, x_q, y_d, y_q;
    logic [3:0]        opcode_d, opcode_q;
    logic [4:0]        rc_d, rc_q;
    logic              alu_en_d, alu_en_q;

    // Writes arriving while reset is asserted are discarded.
    assign rf_we = WbEnable && Reset;

    register_file #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT)
    ) u_register_file (
        .clk  (Clock),
        .we   (rf_we),
        .wa   (WbRc),
        .wd   (WbData),
        .ra_a (Ra),
        .ra_b (Rb),
        .rd_a (rf_a_dat),
        .rd_b (rf_b_dat)
    );

    // Operand selection: zero register, then youngest bypass source first.
    // WB matching here doubles as write-through for a same-cycle read of the written register.
    always_comb begin
        opa_dat = rf_a_dat;
        if (Ra == REG_ZERO) begin
            opa_dat = '0;
        end else if (ExValid && (ExRc == Ra)) begin
            opa_dat = ExZ;
        end else if (MemValid && (MemRc == Ra)) begin
            opa_dat = MemData;
        end else if (WbEnable && (WbRc == Ra)) begin
            opa_dat = WbData;
        end

        opb_dat = rf_b_dat;
        if (UseLit) begin
            opb_dat = {{(DATA_W-16){Literal[15]}}, Literal};
        end else if (Rb == REG_ZERO) begin
            opb_dat = '0;
        end else if (ExValid && (ExRc == Rb)) begin
            opb_dat = ExZ;
        end else if (MemValid && (MemRc == Rb)) begin
            opb_dat = MemData;
        end else if (WbEnable && (WbRc == Rb)) begin
            opb_dat = WbData;
        end
    end

    // Load-use interlock: the EX result is not yet the loaded value, so wait one cycle.
    // Flush and reset both suppress the stall since the instruction is being dropped anyway.
    always_comb begin
        load_use = InValid && ExValid && ExIsLoad && (ExRc != REG_ZERO) &&
                   ((ExRc == Ra) || (!UseLit && (ExRc == Rb)));
        Stall    = load_use && !Flush && Reset;
        accept   = InValid && !Flush && !load_use;
    end

    // Next-state for the ALU input register: load on accept, otherwise hold data and bubble.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        opcode_d = opcode_q;
        rc_d     = rc_q;
        alu_en_d = 1'b0;
        if (accept) begin
            x_d      = opa_dat;
            y_d      = opb_dat;
            opcode_d = OpCodeIn;
            rc_d     = Rc;
            alu_en_d = 1'b1;
        end
    end

    // ALU input register with synchronous active-low reset; RcOut resets to the zero register.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            x_q      <= '0;
            y_q      <= '0;
            opcode_q <= '0;
            rc_q     <= REG_ZERO;
            alu_en_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            opcode_q <= opcode_d;
            rc_q     <= rc_d;
            alu_en_q <= alu_en_d;
        end
    end

    assign X         = x_q;
    assign Y         = y_q;
    assign OpCode    = opcode_q;
    assign RcOut     = rc_q;
    assign AluEnable = alu_en_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench for operand_fetch_unit: vector table plus multi-cycle stall/reset sequences.
// Inputs change on the falling edge; Stall is sampled mid-low-phase, outputs 1 ns after the rising edge.
// Upstream honours Stall by re-presenting the same instruction.
module tb_operand_fetch_unit;

    logic        clk;
    logic        rst;
    logic        inv;
    logic [4:0]  ra, rb, rc;
    logic        ul;
    logic [15:0] lit;
    logic [3:0]  op;
    logic        fl;
    logic        exv, exld;
    logic [4:0]  exrc;
    logic [31:0] exz;
    logic        memv;
    logic [4:0]  memrc;
    logic [31:0] memd;
    logic        wbe;
    logic [4:0]  wbrc;
    logic [31:0] wbd;
    logic [31:0] x_o, y_o;
    logic [3:0]  op_o;
    logic        en_o;
    logic [4:0]  rc_o;
    logic        stall_o;

    int n_cmp = 0;
    int n_bad = 0;

    operand_fetch_unit #(.DATA_W(32), .REG_CNT(32)) dut (
        .Clock(clk), .Reset(rst), .InValid(inv), .Ra(ra), .Rb(rb), .Rc(rc),
        .UseLit(ul), .Literal(lit), .OpCodeIn(op), .Flush(fl),
        .ExValid(exv), .ExIsLoad(exld), .ExRc(exrc), .ExZ(exz),
        .MemValid(memv), .MemRc(memrc), .MemData(memd),
        .WbEnable(wbe), .WbRc(wbrc), .WbData(wbd),
        .X(x_o), .Y(y_o), .OpCode(op_o), .AluEnable(en_o), .RcOut(rc_o), .Stall(stall_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst, inv;
        logic [4:0]  ra, rb, rc;
        logic        ul;
        logic [15:0] lit;
        logic [3:0]  op;
        logic        fl, exv, exld;
        logic [4:0]  exrc;
        logic [31:0] exz;
        logic        memv;
        logic [4:0]  memrc;
        logic [31:0] memd;
        logic        wbe;
        logic [4:0]  wbrc;
        logic [31:0] wbd;
        logic        e_stall, e_en;
        logic [31:0] e_x, e_y;
        logic [3:0]  e_op;
        logic [4:0]  e_rc;
    } vec_t;

    vec_t tbl[$];
    vec_t v;

    function automatic vec_t mk();
        vec_t r;
        r.rst = 1'b1; r.inv = 1'b0; r.ra = 5'd31; r.rb = 5'd31; r.rc = 5'd31;
        r.ul = 1'b0; r.lit = 16'h0; r.op = 4'h0; r.fl = 1'b0;
        r.exv = 1'b0; r.exld = 1'b0; r.exrc = 5'd31; r.exz = 32'h0;
        r.memv = 1'b0; r.memrc = 5'd31; r.memd = 32'h0;
        r.wbe = 1'b0; r.wbrc = 5'd31; r.wbd = 32'h0;
        r.e_stall = 1'b0; r.e_en = 1'b0; r.e_x = 32'h0; r.e_y = 32'h0;
        r.e_op = 4'h0; r.e_rc = 5'd31;
        return r;
    endfunction

    function automatic vec_t iss(input vec_t r, input logic [4:0] a, input logic [4:0] b,
                                 input logic [4:0] c, input logic [3:0] o);
        vec_t t = r;
        t.inv = 1'b1; t.ra = a; t.rb = b; t.rc = c; t.op = o;
        return t;
    endfunction

    task automatic add(input vec_t r, input logic st, input logic en, input logic [31:0] x,
                       input logic [31:0] y, input logic [3:0] o, input logic [4:0] c);
        vec_t t = r;
        t.e_stall = st; t.e_en = en; t.e_x = x; t.e_y = y; t.e_op = o; t.e_rc = c;
        tbl.push_back(t);
    endtask

    task automatic drive(input vec_t r);
        rst = r.rst; inv = r.inv; ra = r.ra; rb = r.rb; rc = r.rc;
        ul = r.ul; lit = r.lit; op = r.op; fl = r.fl;
        exv = r.exv; exld = r.exld; exrc = r.exrc; exz = r.exz;
        memv = r.memv; memrc = r.memrc; memd = r.memd;
        wbe = r.wbe; wbrc = r.wbrc; wbd = r.wbd;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic en, input logic [31:0] x,
                           input logic [31:0] y, input logic [3:0] o, input logic [4:0] c);
        chk({tag, ".en"}, {31'b0, en_o}, {31'b0, en});
        chk({tag, ".x"},  x_o, x);
        chk({tag, ".y"},  y_o, y);
        chk({tag, ".op"}, {28'b0, op_o}, {28'b0, o});
        chk({tag, ".rc"}, {27'b0, rc_o}, {27'b0, c});
    endtask

    initial begin
        drive(mk());
        rst = 1'b0;

        // 0: reset
        v = mk(); v.rst = 1'b0;                                   add(v, 0, 0, 0, 0, 0, 31);
        // 1: write R3 = 0x10, no instruction
        v = mk(); v.wbe = 1; v.wbrc = 3; v.wbd = 32'h10;          add(v, 0, 0, 0, 0, 0, 31);
        // 2: Ra=3, Rb=31
        v = iss(mk(), 3, 31, 4, 2);                               add(v, 0, 1, 32'h10, 0, 2, 4);
        // 3: EX wins over MEM on Ra=5
        v = iss(mk(), 5, 3, 6, 1); v.exv = 1; v.exrc = 5; v.exz = 32'hAAAA_5555;
        v.memv = 1; v.memrc = 5; v.memd = 32'h1;                  add(v, 0, 1, 32'hAAAA_5555, 32'h10, 1, 6);
        // 4: MEM bypass on Rb, R31 on Ra
        v = iss(mk(), 31, 3, 7, 3); v.memv = 1; v.memrc = 3; v.memd = 32'h55;
                                                                  add(v, 0, 1, 0, 32'h55, 3, 7);
        // 5: negative literal
        v = iss(mk(), 3, 7, 8, 4); v.ul = 1; v.lit = 16'hFFFE;    add(v, 0, 1, 32'h10, 32'hFFFF_FFFE, 4, 8);
        // 6: positive literal
        v = iss(mk(), 31, 0, 9, 5); v.ul = 1; v.lit = 16'h7FFF;   add(v, 0, 1, 0, 32'h0000_7FFF, 5, 9);
        // 7: load-use on Rb -> stall, bubble, hold
        v = iss(mk(), 3, 7, 10, 6); v.exv = 1; v.exld = 1; v.exrc = 7;
                                                                  add(v, 1, 0, 0, 32'h0000_7FFF, 5, 9);
        // 8: same but UseLit -> no stall
        v.ul = 1; v.lit = 16'h0001;                               add(v, 0, 1, 32'h10, 32'h1, 6, 10);
        // 9: WB to R31 with Ra=Rb=31 -> zeros
        v = iss(mk(), 31, 31, 11, 7); v.wbe = 1; v.wbrc = 31; v.wbd = 32'h1234;
                                                                  add(v, 0, 1, 0, 0, 7, 11);
        // 10: R31 still zero afterwards
        v = iss(mk(), 31, 31, 12, 8);                             add(v, 0, 1, 0, 0, 8, 12);
        // 11: same-cycle write/read of R9 -> write-through
        v = iss(mk(), 9, 9, 13, 9); v.wbe = 1; v.wbrc = 9; v.wbd = 32'hCAFE;
                                                                  add(v, 0, 1, 32'hCAFE, 32'hCAFE, 9, 13);
        // 12: R9 stored
        v = iss(mk(), 9, 3, 14, 10);                              add(v, 0, 1, 32'hCAFE, 32'h10, 10, 14);
        // 13: Flush overrides a load-use stall
        v = iss(mk(), 9, 31, 15, 11); v.exv = 1; v.exld = 1; v.exrc = 9; v.fl = 1;
                                                                  add(v, 0, 0, 32'hCAFE, 32'h10, 10, 14);
        // 14: InValid=0 with a load hazard on Ra -> no stall, bubble, hold
        v = mk(); v.ra = 3; v.exv = 1; v.exld = 1; v.exrc = 3;    add(v, 0, 0, 32'hCAFE, 32'h10, 10, 14);
        // 15: reset with a WB write that must be ignored
        v = mk(); v.rst = 0; v.wbe = 1; v.wbrc = 3; v.wbd = 32'hDEAD;
                                                                  add(v, 0, 0, 0, 0, 0, 31);
        // 16: R3 unchanged by the write during reset
        v = iss(mk(), 3, 31, 2, 1);                               add(v, 0, 1, 32'h10, 0, 1, 2);
        // 17: MEM wins over WB; WB still writes R3
        v = iss(mk(), 3, 3, 5, 2); v.memv = 1; v.memrc = 3; v.memd = 32'h77;
        v.wbe = 1; v.wbrc = 3; v.wbd = 32'h99;                    add(v, 0, 1, 32'h77, 32'h77, 2, 5);
        // 18: R3 now holds the WB value
        v = iss(mk(), 3, 31, 6, 3);                               add(v, 0, 1, 32'h99, 0, 3, 6);
        // 19: EX/MEM targeting R31 never bypass
        v = iss(mk(), 31, 31, 7, 4); v.exv = 1; v.exrc = 31; v.exz = 32'hFFFF;
        v.memv = 1; v.memrc = 31; v.memd = 32'h1;                 add(v, 0, 1, 0, 0, 4, 7);
        // 20: non-zero X before the hand sequences
        v = iss(mk(), 3, 31, 8, 5);                               add(v, 0, 1, 32'h99, 0, 5, 8);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d.stall", i), {31'b0, stall_o}, {31'b0, tbl[i].e_stall});
            @(posedge clk);
            #1;
            chk_out($sformatf("v%0d", i), tbl[i].e_en, tbl[i].e_x, tbl[i].e_y, tbl[i].e_op, tbl[i].e_rc);
        end

        // Stall held for two cycles, then the load result arrives via MEM
        v = iss(mk(), 3, 31, 9, 6); v.exv = 1; v.exld = 1; v.exrc = 3;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(v);
            #1;
            chk($sformatf("hold%0d.stall", c), {31'b0, stall_o}, 32'd1);
            @(posedge clk);
            #1;
            chk_out($sformatf("hold%0d", c), 0, 32'h99, 0, 5, 8);
        end
        @(negedge clk);
        v.exv = 0; v.exld = 0; v.memv = 1; v.memrc = 3; v.memd = 32'hBEEF;
        drive(v);
        #1;
        chk("release.stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk);
        #1;
        chk_out("release", 1, 32'hBEEF, 0, 6, 9);

        // Reset asserted mid-cycle while stalling
        @(negedge clk);
        v = iss(mk(), 3, 31, 10, 7); v.exv = 1; v.exld = 1; v.exrc = 3;
        drive(v);
        #1;
        chk("rststall.pre", {31'b0, stall_o}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("rststall.stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk);
        #1;
        chk_out("rststall", 0, 0, 0, 0, 31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
